vx_om_sched: RTL and testbench
==============================

# VX_om_sched

Fragment scheduler in front of the output-merger datapath. Round-robin arbitrates among `NUM_REQS` requesters and issues one fragment per cycle to the OM datapath. Tracks in-flight pixels in a small hazard table so no two fragments to the same (rt_idx, x, y) are in the read-modify-write pipeline together. Retires table entries on datapath completion.

## Interface
- `NUM_REQS`, 4: number of requesters (≥1).
- `INFLIGHT`, 8: hazard table entries, the maximum number of outstanding fragments (power of 2).
- `DATA_WIDTH`, 64: opaque per-fragment payload (color/depth/mask) passed through untouched.
- `TAG_W`, derived: log2(`INFLIGHT`), min 1.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `NUM_REQS`: per-requester valid.
- `req_rt_idx` in `NUM_REQS`×2: render-target index.
- `req_pos_x`, `req_pos_y` in `NUM_REQS`×`VX_OM_DIM_BITS`: pixel coordinates.
- `req_data` in `NUM_REQS`×`DATA_WIDTH`: payload.
- `req_ready` out `NUM_REQS`: grant/accept; high only for the granted requester.
- `out_valid` out 1: fragment to datapath.
- `out_rt_idx`, `out_pos_x`, `out_pos_y`, `out_data` out: registered copy of the granted request.
- `out_tag` out `TAG_W`: allocated hazard-table slot.
- `out_ready` in 1: datapath accepts.
- `done_valid` in 1: datapath retired a fragment. Always accepted.
- `done_tag` in `TAG_W`: slot to free.
- `busy` out 1: any table entry valid or `out_valid`.

## Operation
- Hazard table: `INFLIGHT` entries {valid, rt_idx, pos_x, pos_y}. A requester is blocked if its (rt_idx, x, y) matches any valid entry. The compare uses pre-update (registered) table state.
- Eligible requester: `req_valid` set, not blocked. A grant also needs a free slot and an output register that is empty or draining (`!out_valid || out_ready`).
- Arbitration: round-robin over eligible requesters. Priority starts at `rr_ptr`. After a grant to i, `rr_ptr` = (i+1) mod `NUM_REQS`. `rr_ptr` is unchanged when there is no grant.
- Grant: at most one per cycle.
  - Assert `req_ready[i]` combinationally.
  - Allocate the lowest-index free slot and write {1, rt_idx, x, y}.
  - Load the output register with the request and `out_tag` = slot.
- Two requesters with the same pixel in one cycle: only the winner is granted. The loser is blocked next cycle by the new entry.
- Done: clears `valid[done_tag]` at the clock edge.
  - Done to an already-free slot: ignored; simulation assertion fires.
  - The freed entry still blocks and still counts as occupied in the done cycle.
- Per-requester ordering: strictly in order. Cross-requester same-pixel order equals grant order.
- Table full (all valid): no grants; `req_ready` all 0.
- Reset:
  - Table cleared, `rr_ptr`=0.
  - `out_valid`=0, `out_*` data=0, `out_tag`=0.
  - `req_ready`=0, `busy`=0.
  - Reset mid-operation discards all in-flight state. Stale `done_valid` after reset hits a free slot and is ignored.

## Timing
- Grant at cycle t → `out_valid` at t+1. `out_*` are held stable while `out_valid && !out_ready`.
- Throughput: 1 fragment/cycle with `out_ready` high and no hazards.
- Slot freed by done at t is allocatable at t+1.
- Blocked request whose hazard retires at t: granted at t+1 earliest, `out_valid` at t+2.
- Done and grant in the same cycle on different slots: both take effect.
- `busy` is registered and reflects state after the current edge.

## Structure
- `VX_om_pkg` gains:
  - `om_sched_entry_t` {rt_idx[1:0], pos_x, pos_y[`VX_OM_DIM_BITS`]}.
  - `om_sched_req_t` {entry, data} (data width as parameterized).
- Sub-module: `VX_rr_arbiter` (NUM_REQS, with lock on grant). The rest is inline: the hazard CAM compare, the lowest-free-slot priority encoder, and the output register.

## Test plan
- Single requester, 8 distinct pixels, `out_ready`=1, no done: tags 0..7 issue on consecutive cycles. 9th stalls (`req_ready`=0) until done_tag=3 at t → 9th granted t+1 with tag 3.
- Req0 and req2 both (rt 0, x=5, y=5), `rr_ptr`=0: req0 granted. Req2 blocked until done for req0's tag. Req2 issues 2 cycles after done.
- All 4 requesters valid, distinct pixels, continuous: grant order 0,1,2,3,0,…; one grant per cycle.
- `out_ready`=0 for 3 cycles after first grant: `out_*` stable, no further grants. Resumes 1/cycle when `out_ready`=1.
- Same (x,y) with rt_idx 0 vs 1: not a hazard; both issue back-to-back.
- Reset asserted with 5 entries in flight and `out_valid`=1: next cycle `out_valid`=0, `busy`=0. New request gets tag 0; a stale done_tag=2 is ignored with the assertion flagged.

Source files
------------

// File: rtl/vx_om_sched_pkg.sv
// Shared types for the output-merger fragment scheduler.
package vx_om_sched_pkg;

  localparam int unsigned VX_OM_DIM_BITS = 12;

  // Pixel identity tracked by the hazard table.
  typedef struct packed {
    logic [1:0]                rt_idx;
    logic [VX_OM_DIM_BITS-1:0] pos_x;
    logic [VX_OM_DIM_BITS-1:0] pos_y;
  } om_sched_entry_t;

  // True when a live table entry targets the same pixel as a request.
  function automatic logic entry_hit(input logic valid,
                                     input om_sched_entry_t a,
                                     input om_sched_entry_t b);
    return valid && (a == b);
  endfunction

endpackage

// File: rtl/vx_om_sched_if.sv
// Request, datapath-issue and retire signals of the fragment scheduler.
interface vx_om_sched_if
  import vx_om_sched_pkg::*;
#(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TAG_W      = 3
);
  logic [NUM_REQS-1:0]                     req_valid;
  logic [NUM_REQS-1:0][1:0]                req_rt_idx;
  logic [NUM_REQS-1:0][VX_OM_DIM_BITS-1:0] req_pos_x;
  logic [NUM_REQS-1:0][VX_OM_DIM_BITS-1:0] req_pos_y;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]     req_data;
  logic [NUM_REQS-1:0]                     req_ready;

  logic                      out_valid;
  logic [1:0]                out_rt_idx;
  logic [VX_OM_DIM_BITS-1:0] out_pos_x;
  logic [VX_OM_DIM_BITS-1:0] out_pos_y;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [TAG_W-1:0]          out_tag;
  logic                      out_ready;

  logic                      done_valid;
  logic [TAG_W-1:0]          done_tag;
  logic                      busy;

  modport master (
    output req_valid, req_rt_idx, req_pos_x, req_pos_y, req_data,
    input  req_ready,
    input  out_valid, out_rt_idx, out_pos_x, out_pos_y, out_data, out_tag,
    output out_ready, done_valid, done_tag,
    input  busy
  );

  modport slave (
    input  req_valid, req_rt_idx, req_pos_x, req_pos_y, req_data,
    output req_ready,
    output out_valid, out_rt_idx, out_pos_x, out_pos_y, out_data, out_tag,
    input  out_ready, done_valid, done_tag,
    output busy
  );
endinterface

// File: rtl/vx_om_sched_rr_arbiter.sv
// Round-robin arbiter; the priority pointer only advances on an actual grant.
module vx_om_sched_rr_arbiter #(
  parameter int unsigned NUM_REQS = 4,
  localparam int unsigned IDX_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic [NUM_REQS-1:0] i_requests,
  input  logic                i_enable,
  output logic [NUM_REQS-1:0] o_grant,
  output logic [IDX_W-1:0]    o_grant_idx,
  output logic                o_valid
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_next;

  // Scan requesters starting at r_ptr, first hit wins.
  always_comb begin
    int unsigned v_idx;
    v_idx       = 0;
    o_grant     = '0;
    o_grant_idx = '0;
    o_valid     = 1'b0;
    w_ptr_next  = r_ptr;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      v_idx = 32'(r_ptr) + k;
      if (v_idx >= NUM_REQS) v_idx = v_idx - NUM_REQS;
      if (i_enable && !o_valid && i_requests[v_idx[IDX_W-1:0]]) begin
        o_valid                     = 1'b1;
        o_grant[v_idx[IDX_W-1:0]]   = 1'b1;
        o_grant_idx                 = v_idx[IDX_W-1:0];
        w_ptr_next = (v_idx + 1 >= NUM_REQS) ? '0 : IDX_W'(v_idx + 1);
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (i_reset)      r_ptr <= '0;
    else if (o_valid) r_ptr <= w_ptr_next;
  end

endmodule

// File: rtl/vx_om_sched.sv
// Fragment scheduler: round-robin grant, pixel hazard table, registered issue.
module vx_om_sched
  import vx_om_sched_pkg::*;
#(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned INFLIGHT   = 8,
  parameter int unsigned DATA_WIDTH = 64
) (
  input logic          clk,
  input logic          reset,
  vx_om_sched_if.slave bus
);

  localparam int unsigned TAG_W = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
  localparam int unsigned IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  typedef struct packed {
    om_sched_entry_t       entry;
    logic [DATA_WIDTH-1:0] data;
  } om_sched_req_t;

  logic [INFLIGHT-1:0] r_valid;
  logic [INFLIGHT-1:0] w_valid_next;
  om_sched_entry_t     r_entry [INFLIGHT];
  om_sched_req_t       w_req   [NUM_REQS];

  logic [NUM_REQS-1:0] w_blocked;
  logic [NUM_REQS-1:0] w_eligible;
  logic [NUM_REQS-1:0] w_grant;
  logic [IDX_W-1:0]    w_grant_idx;
  logic                w_grant_valid;
  logic                w_free_found;
  logic [TAG_W-1:0]    w_free_slot;
  logic                w_can_issue;
  logic                w_out_valid_next;

  om_sched_req_t       r_out;
  logic                r_out_valid;
  logic [TAG_W-1:0]    r_out_tag;
  logic                r_busy;

  // Gather per-requester fields into request structs.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      w_req[i].entry.rt_idx = bus.req_rt_idx[i];
      w_req[i].entry.pos_x  = bus.req_pos_x[i];
      w_req[i].entry.pos_y  = bus.req_pos_y[i];
      w_req[i].data         = bus.req_data[i];
    end
  end

  // Hazard CAM against the registered table; a slot retiring this cycle still blocks.
  always_comb begin
    w_blocked = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++)
      for (int unsigned s = 0; s < INFLIGHT; s++)
        if (entry_hit(r_valid[s], r_entry[s], w_req[i].entry)) w_blocked[i] = 1'b1;
  end

  // Lowest-index free slot.
  always_comb begin
    w_free_found = 1'b0;
    w_free_slot  = '0;
    for (int unsigned s = 0; s < INFLIGHT; s++) begin
      if (!w_free_found && !r_valid[s]) begin
        w_free_found = 1'b1;
        w_free_slot  = TAG_W'(s);
      end
    end
  end

  assign w_eligible  = bus.req_valid & ~w_blocked;
  assign w_can_issue = !reset && w_free_found && (!r_out_valid || bus.out_ready);

  vx_om_sched_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_arb (
    .clk         (clk),
    .i_reset     (reset),
    .i_requests  (w_eligible),
    .i_enable    (w_can_issue),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_valid     (w_grant_valid)
  );

  // Next table occupancy: retire first, then allocate (slots never coincide).
  always_comb begin
    w_valid_next = r_valid;
    if (bus.done_valid) w_valid_next[bus.done_tag] = 1'b0;
    if (w_grant_valid)  w_valid_next[w_free_slot]  = 1'b1;
    w_out_valid_next = w_grant_valid | (r_out_valid & ~bus.out_ready);
  end

  // Table, output register and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      r_busy      <= 1'b0;
      for (int unsigned s = 0; s < INFLIGHT; s++) r_entry[s] <= '0;
    end else begin
      r_valid     <= w_valid_next;
      r_out_valid <= w_out_valid_next;
      r_busy      <= (|w_valid_next) | w_out_valid_next;
      if (w_grant_valid) begin
        r_entry[w_free_slot] <= w_req[w_grant_idx].entry;
        r_out                <= w_req[w_grant_idx];
        r_out_tag            <= w_free_slot;
      end
    end
  end

  // Flag a retire aimed at a slot that holds nothing; the retire itself is a no-op.
  always_ff @(posedge clk) begin
    if (!reset && bus.done_valid)
      assert (r_valid[bus.done_tag])
      else $warning("vx_om_sched: done_tag %0d targets a free slot", bus.done_tag);
  end

  assign bus.req_ready  = w_grant;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_rt_idx = r_out.entry.rt_idx;
  assign bus.out_pos_x  = r_out.entry.pos_x;
  assign bus.out_pos_y  = r_out.entry.pos_y;
  assign bus.out_data   = r_out.data;
  assign bus.out_tag    = r_out_tag;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_vx_om_sched.sv
// Directed self-checking bench for vx_om_sched.
module tb_vx_om_sched;
  import vx_om_sched_pkg::*;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  vx_om_sched_if #(.NUM_REQS(4), .DATA_WIDTH(64), .TAG_W(3)) bus ();

  vx_om_sched #(.NUM_REQS(4), .INFLIGHT(8), .DATA_WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input logic [1:0] i, input logic [1:0] rt,
                         input logic [11:0] x, input logic [11:0] y,
                         input logic [63:0] d);
    bus.req_valid[i]  = 1'b1;
    bus.req_rt_idx[i] = rt;
    bus.req_pos_x[i]  = x;
    bus.req_pos_y[i]  = y;
    bus.req_data[i]   = d;
  endtask

  task automatic drop(input logic [1:0] i);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.req_valid  = '0;
    bus.req_rt_idx = '0;
    bus.req_pos_x  = '0;
    bus.req_pos_y  = '0;
    bus.req_data   = '0;
    bus.out_ready  = 1'b1;
    bus.done_valid = 1'b0;
    bus.done_tag   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] m;
    int         e;
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_inputs();
    set_req(0, 0, 12'd1, 12'd1, 64'hAA);
    tick();
    tick();
    settle();
    chk("rst req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst busy",      64'(bus.busy),      64'h0);
    chk("rst out_tag",   64'(bus.out_tag),   64'h0);
    chk("rst out_data",  bus.out_data,       64'h0);
    reset = 1'b0;

    // Single requester fills all eight slots, tags 0..7 back to back.
    for (int k = 0; k < 8; k++) begin
      set_req(0, 0, 12'(k), 12'd1, 64'(100 + k));
      settle();
      chk("A ready", 64'(bus.req_ready), 64'h1);
      tick();
      chk("A out_valid", 64'(bus.out_valid), 64'h1);
      chk("A out_tag",   64'(bus.out_tag),   64'(k));
      chk("A out_pos_x", 64'(bus.out_pos_x), 64'(k));
      chk("A out_data",  bus.out_data,       64'(100 + k));
    end
    set_req(0, 0, 12'd8, 12'd1, 64'd108);
    settle();
    chk("A full ready", 64'(bus.req_ready), 64'h0);
    tick();
    chk("A drained out_valid", 64'(bus.out_valid), 64'h0);
    chk("A busy", 64'(bus.busy), 64'h1);
    bus.done_valid = 1'b1;
    bus.done_tag   = 3'd3;
    settle();
    chk("A done-cycle ready", 64'(bus.req_ready), 64'h0);
    tick();
    bus.done_valid = 1'b0;
    settle();
    chk("A freed ready", 64'(bus.req_ready), 64'h1);
    tick();
    chk("A reuse out_valid", 64'(bus.out_valid), 64'h1);
    chk("A reuse out_tag",   64'(bus.out_tag),   64'h3);
    chk("A reuse out_pos_x", 64'(bus.out_pos_x), 64'h8);
    drop(0);
    for (int t = 0; t < 8; t++) begin
      bus.done_valid = 1'b1;
      bus.done_tag   = 3'(t);
      tick();
    end
    bus.done_valid = 1'b0;
    chk("A idle busy", 64'(bus.busy), 64'h0);
    do_reset();

    // Same pixel from req0 and req2: req0 wins, req2 waits for retire.
    set_req(0, 0, 12'd5, 12'd5, 64'hB0);
    set_req(2, 0, 12'd5, 12'd5, 64'hB2);
    settle();
    chk("B first ready", 64'(bus.req_ready), 64'h1);
    tick();
    chk("B out_tag",  64'(bus.out_tag), 64'h0);
    chk("B out_data", bus.out_data,     64'hB0);
    drop(0);
    settle();
    chk("B blocked1", 64'(bus.req_ready), 64'h0);
    tick();
    chk("B blocked2", 64'(bus.req_ready), 64'h0);
    tick();
    bus.done_valid = 1'b1;
    bus.done_tag   = 3'd0;
    settle();
    chk("B blocked in done cycle", 64'(bus.req_ready), 64'h0);
    tick();
    bus.done_valid = 1'b0;
    settle();
    chk("B unblocked ready", 64'(bus.req_ready), 64'h4);
    chk("B out_valid t+1",   64'(bus.out_valid), 64'h0);
    tick();
    chk("B out_valid t+2", 64'(bus.out_valid), 64'h1);
    chk("B out_tag2",      64'(bus.out_tag),   64'h0);
    chk("B out_data2",     bus.out_data,       64'hB2);
    do_reset();

    // Four requesters, distinct pixels: strict rotation, one grant per cycle.
    for (int i = 0; i < 4; i++) set_req(2'(i), 0, 12'(i), 12'd20, 64'(i));
    for (int c = 0; c < 8; c++) begin
      e = c % 4;
      m = 4'b0001 << e;
      settle();
      chk("C grant", 64'(bus.req_ready), 64'(m));
      tick();
      chk("C out_tag",  64'(bus.out_tag), 64'(c));
      chk("C out_data", bus.out_data,     (c < 4) ? 64'(c) : 64'(100 + c - 4));
      set_req(2'(e), 0, 12'(e), 12'(21 + c), 64'(100 + c));
    end
    settle();
    chk("C full ready", 64'(bus.req_ready), 64'h0);
    do_reset();

    // Output backpressure holds the register and stops grants.
    set_req(0, 0, 12'd1, 12'd30, 64'hD0);
    set_req(1, 0, 12'd2, 12'd30, 64'hD1);
    settle();
    chk("D first ready", 64'(bus.req_ready), 64'h1);
    tick();
    chk("D out_tag",  64'(bus.out_tag), 64'h0);
    chk("D out_data", bus.out_data,     64'hD0);
    set_req(0, 0, 12'd3, 12'd30, 64'hD2);
    bus.out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      settle();
      chk("D stall ready",     64'(bus.req_ready), 64'h0);
      chk("D stall out_valid", 64'(bus.out_valid), 64'h1);
      chk("D stall out_data",  bus.out_data,       64'hD0);
      chk("D stall out_tag",   64'(bus.out_tag),   64'h0);
      tick();
    end
    bus.out_ready = 1'b1;
    settle();
    chk("D resume ready", 64'(bus.req_ready), 64'h2);
    tick();
    chk("D resume out_tag",  64'(bus.out_tag), 64'h1);
    chk("D resume out_data", bus.out_data,     64'hD1);
    drop(1);
    settle();
    chk("D next ready", 64'(bus.req_ready), 64'h1);
    tick();
    chk("D next out_tag",  64'(bus.out_tag), 64'h2);
    chk("D next out_data", bus.out_data,     64'hD2);
    do_reset();

    // Same (x,y) on different render targets is not a hazard.
    set_req(0, 2'd0, 12'd7, 12'd7, 64'hE0);
    set_req(1, 2'd1, 12'd7, 12'd7, 64'hE1);
    settle();
    chk("E ready0", 64'(bus.req_ready), 64'h1);
    tick();
    chk("E out_rt0", 64'(bus.out_rt_idx), 64'h0);
    drop(0);
    settle();
    chk("E ready1", 64'(bus.req_ready), 64'h2);
    tick();
    chk("E out_rt1",    64'(bus.out_rt_idx), 64'h1);
    chk("E out_tag1",   64'(bus.out_tag),    64'h1);
    chk("E out_valid1", 64'(bus.out_valid),  64'h1);
    do_reset();

    // Reset with five fragments in flight, then a stale retire.
    for (int k = 0; k < 5; k++) begin
      set_req(0, 0, 12'(k), 12'd40, 64'(200 + k));
      tick();
    end
    chk("F pre busy",      64'(bus.busy),      64'h1);
    chk("F pre out_valid", 64'(bus.out_valid), 64'h1);
    chk("F pre out_tag",   64'(bus.out_tag),   64'h4);
    reset = 1'b1;
    drop(0);
    tick();
    chk("F rst out_valid", 64'(bus.out_valid), 64'h0);
    chk("F rst busy",      64'(bus.busy),      64'h0);
    chk("F rst out_tag",   64'(bus.out_tag),   64'h0);
    chk("F rst out_data",  bus.out_data,       64'h0);
    reset          = 1'b0;
    bus.done_valid = 1'b1;
    bus.done_tag   = 3'd2;
    set_req(0, 0, 12'd0, 12'd40, 64'hFF);
    settle();
    chk("F new ready", 64'(bus.req_ready), 64'h1);
    tick();
    chk("F new out_tag",  64'(bus.out_tag), 64'h0);
    chk("F new out_data", bus.out_data,     64'hFF);
    bus.done_valid = 1'b0;
    set_req(0, 0, 12'd9, 12'd40, 64'hFE);
    settle();
    chk("F second ready", 64'(bus.req_ready), 64'h1);
    tick();
    chk("F second out_tag", 64'(bus.out_tag), 64'h1);
    chk("F busy",           64'(bus.busy),    64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
